// File: rtl/axi4l_master.sv
// AXI4-Lite master bridge: turns single load/store requests into one AXI4-Lite
// transaction at a time, with byte-lane steering, strobes, read extension and alignment checks.
module axi4l_master #(
  parameter  int unsigned ADDR_W = 32,
  localparam int unsigned DATA_W = 32,
  localparam int unsigned STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [2:0]        m_axi_awprot,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [STRB_W-1:0] m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [2:0]        m_axi_arprot,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RRESP = 3'd4,
    DONE  = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          lane_q, lane_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                arvalid_q, arvalid_d;
  logic                bready_q, bready_d;
  logic                rready_q, rready_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic                misaligned_c;
  logic [DATA_W-1:0]   wdata_steer_c;
  logic [STRB_W-1:0]   wstrb_steer_c;

  // Pick the addressed byte/halfword out of the read beat and extend it.
  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] d,
                                                    input logic [1:0] lane,
                                                    input logic [1:0] size,
                                                    input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(d >> {lane, 3'b000});
    h = 16'(d >> {lane[1], 4'b0000});
    case (size)
      2'b00:   load_extend = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   load_extend = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: load_extend = d;
    endcase
  endfunction

  always_comb begin
    case (req_size)
      2'b00:   misaligned_c = 1'b0;
      2'b01:   misaligned_c = req_addr[0];
      2'b10:   misaligned_c = (req_addr[1:0] != 2'b00);
      default: misaligned_c = 1'b1;
    endcase
  end

  // Replicate store data across lanes and enable only the addressed bytes.
  always_comb begin
    wdata_steer_c = req_wdata;
    wstrb_steer_c = '0;
    case (req_size)
      2'b00: begin
        wdata_steer_c = {4{req_wdata[7:0]}};
        wstrb_steer_c = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        wdata_steer_c = {2{req_wdata[15:0]}};
        wstrb_steer_c = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10:   wstrb_steer_c = 4'b1111;
      default: wstrb_steer_c = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (misaligned_c) state_d = DONE;
          else if (req_we)  state_d = WADDR;
          else              state_d = RADDR;
        end
      end
      // Each of AW and W completes on its own handshake; leave once both are done.
      WADDR: if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) state_d = WRESP;
      WRESP: if (m_axi_bvalid) state_d = DONE;
      RADDR: if (m_axi_arready) state_d = RRESP;
      RRESP: if (m_axi_rvalid) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of every registered output, derived from the current state and its successor.
  always_comb begin
    lane_d      = lane_q;
    size_d      = size_q;
    uns_d       = uns_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = 1'b0;
    wvalid_d    = 1'b0;
    arvalid_d   = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    req_ready_d = (state_d == IDLE);
    bready_d    = (state_d == WRESP);
    rready_d    = (state_d == RRESP);
    rsp_valid_d = (state_d == DONE);
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          lane_d = req_addr[1:0];
          size_d = req_size;
          uns_d  = req_unsigned;
          if (misaligned_c) begin
            rsp_err_d = 1'b1;
          end else if (req_we) begin
            awaddr_d  = req_addr;
            wdata_d   = wdata_steer_c;
            wstrb_d   = wstrb_steer_c;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            araddr_d  = req_addr;
            arvalid_d = 1'b1;
          end
        end
      end
      WADDR: begin
        awvalid_d = awvalid_q & ~m_axi_awready;
        wvalid_d  = wvalid_q & ~m_axi_wready;
      end
      WRESP: if (m_axi_bvalid) rsp_err_d = (m_axi_bresp != 2'b00);
      RADDR: arvalid_d = arvalid_q & ~m_axi_arready;
      RRESP: begin
        if (m_axi_rvalid) begin
          rsp_rdata_d = load_extend(m_axi_rdata, lane_q, size_q, uns_q);
          rsp_err_d   = (m_axi_rresp != 2'b00);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q      <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      lane_q      <= lane_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi4l_master.sv
// Bench for axi4l_master: directed cases with literal expectations plus a long
// randomized run checked every cycle against a transaction-level model.
module tb_axi4l_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_unsigned = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;

  axi4l_master #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, n_rsp = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- slave model ----------------
  logic        rnd_mode = 1'b0, aw_rnd = 1'b0, w_rnd = 1'b0, ar_rnd = 1'b0;
  int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0]  nxt_bresp = 2'b00, nxt_rresp = 2'b00;
  logic [31:0] nxt_rdata = '0;
  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic        aw_seen, w_seen, b_pend, r_pend;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q;
  logic        aw_hs, w_hs, aw_done, w_done;

  assign m_axi_awready = m_axi_awvalid && (rnd_mode ? aw_rnd : (aw_cnt >= aw_dly));
  assign m_axi_wready  = m_axi_wvalid  && (rnd_mode ? w_rnd  : (w_cnt  >= w_dly));
  assign m_axi_arready = m_axi_arvalid && (rnd_mode ? ar_rnd : (ar_cnt >= ar_dly));
  assign m_axi_bvalid  = b_pend && (b_cnt == 0);
  assign m_axi_rvalid  = r_pend && (r_cnt == 0);
  assign m_axi_bresp   = bresp_q;
  assign m_axi_rresp   = rresp_q;
  assign m_axi_rdata   = rdata_q;
  assign aw_hs   = m_axi_awvalid && m_axi_awready;
  assign w_hs    = m_axi_wvalid && m_axi_wready;
  assign aw_done = aw_seen || aw_hs;
  assign w_done  = w_seen || w_hs;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      aw_seen <= 1'b0; w_seen <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      bresp_q <= '0; rresp_q <= '0; rdata_q <= '0;
    end else begin
      aw_cnt <= (m_axi_awvalid && !m_axi_awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (m_axi_wvalid && !m_axi_wready) ? w_cnt + 1 : 0;
      ar_cnt <= (m_axi_arvalid && !m_axi_arready) ? ar_cnt + 1 : 0;
      if (b_pend && b_cnt != 0) b_cnt <= b_cnt - 1;
      if (r_pend && r_cnt != 0) r_cnt <= r_cnt - 1;
      if (m_axi_bvalid && m_axi_bready) b_pend <= 1'b0;
      if (m_axi_rvalid && m_axi_rready) r_pend <= 1'b0;
      if (aw_done && w_done) begin
        aw_seen <= 1'b0; w_seen <= 1'b0; b_pend <= 1'b1;
        b_cnt   <= rnd_mode ? int'($urandom % 3) : b_dly;
        bresp_q <= rnd_mode ? (($urandom % 4 == 0) ? 2'($urandom) : 2'b00) : nxt_bresp;
      end else begin
        aw_seen <= aw_done; w_seen <= w_done;
      end
      if (m_axi_arvalid && m_axi_arready) begin
        r_pend  <= 1'b1;
        r_cnt   <= rnd_mode ? int'($urandom % 3) : r_dly;
        rresp_q <= rnd_mode ? (($urandom % 4 == 0) ? 2'($urandom) : 2'b00) : nxt_rresp;
        rdata_q <= rnd_mode ? $urandom : nxt_rdata;
      end
    end
  end

  // ---------------- reference rules ----------------
  function automatic logic mis_f(input logic [31:0] a, input logic [1:0] s);
    int unsigned nb;
    if (s == 2'd3) return 1'b1;
    nb = 32'd1 << s;
    return (a % nb) != 0;
  endfunction

  function automatic logic [31:0] st_data(input logic [1:0] s, input logic [31:0] d);
    case (s)
      2'd0:    return (d % 256) * 32'h0101_0101;
      2'd1:    return (d % 65536) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] st_strb(input logic [1:0] s, input logic [31:0] a);
    case (s)
      2'd0:    return 4'(32'd1 << (a % 4));
      2'd1:    return 4'(32'd3 << ((a / 2) % 2 * 2));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] ld_data(input logic [1:0] s, input logic [31:0] a,
                                          input logic u, input logic [31:0] raw);
    int unsigned v;
    case (s)
      2'd0: begin
        v = (raw >> (8 * (a % 4))) % 256;
        if (!u && v >= 128) v = v - 256;
      end
      2'd1: begin
        v = (raw >> (16 * ((a / 2) % 2))) % 65536;
        if (!u && v >= 32768) v = v - 65536;
      end
      default: v = raw;
    endcase
    return v;
  endfunction

  // ---------------- cycle compare against transaction model ----------------
  initial begin : cmp
    logic outst, aw_p, w_p, ar_p, b_ph, r_ph, due, e_err, e_uns;
    logic acc, awh, wh, arh, bh, rh, both;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_wstrb;
    logic [1:0]  e_size;
    outst = 0; aw_p = 0; w_p = 0; ar_p = 0; b_ph = 0; r_ph = 0; due = 0;
    e_err = 0; e_uns = 0; e_addr = 0; e_wdata = 0; e_rdata = 0; e_wstrb = 0; e_size = 0;
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        outst = 0; aw_p = 0; w_p = 0; ar_p = 0; b_ph = 0; r_ph = 0; due = 0;
      end else begin
        chk("ctrl{rdy,aw,w,ar,b,r,rsp}",
            32'({req_ready, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid}),
            32'({!outst, aw_p, w_p, ar_p, b_ph, r_ph, due}));
        if (m_axi_awvalid) chk("awaddr", m_axi_awaddr, e_addr);
        if (m_axi_wvalid) begin
          chk("wdata", m_axi_wdata, e_wdata);
          chk("wstrb", 32'(m_axi_wstrb), 32'(e_wstrb));
        end
        if (m_axi_arvalid) chk("araddr", m_axi_araddr, e_addr);
        if (rsp_valid) begin
          chk("rsp_err", 32'(rsp_err), 32'(e_err));
          chk("rsp_rdata", rsp_rdata, e_rdata);
          n_rsp++;
        end
        acc  = req_valid && !outst;
        awh  = aw_p && m_axi_awready;
        wh   = w_p && m_axi_wready;
        arh  = ar_p && m_axi_arready;
        bh   = b_ph && m_axi_bvalid;
        rh   = r_ph && m_axi_rvalid;
        both = (aw_p || w_p) && (!aw_p || awh) && (!w_p || wh);
        if (bh) begin e_err = (m_axi_bresp != 0); e_rdata = 0; end
        if (rh) begin
          e_err = (m_axi_rresp != 0);
          e_rdata = ld_data(e_size, e_addr, e_uns, m_axi_rdata);
        end
        outst = (outst && !due) || acc;
        due   = bh || rh || (acc && mis_f(req_addr, req_size));
        b_ph  = (b_ph && !bh) || both;
        r_ph  = (r_ph && !rh) || arh;
        aw_p  = aw_p && !awh;
        w_p   = w_p && !wh;
        ar_p  = ar_p && !arh;
        if (acc) begin
          e_addr = req_addr; e_size = req_size; e_uns = req_unsigned;
          if (mis_f(req_addr, req_size)) begin
            e_err = 1; e_rdata = 0;
          end else if (req_we) begin
            aw_p = 1; w_p = 1;
            e_wdata = st_data(req_size, req_wdata);
            e_wstrb = st_strb(req_size, req_addr);
          end else begin
            ar_p = 1;
          end
        end
      end
    end
  end

  // ---------------- directed driver ----------------
  int          lat, aw_first, aw_last, w_last;
  logic        saw_ar;
  logic [31:0] c_rdata, c_wdata, c_awaddr;
  logic [3:0]  c_wstrb;
  logic        c_err;

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ctrl"}, 32'({req_ready, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                             m_axi_bready, m_axi_rready, rsp_valid, rsp_err}), 32'h80);
    chk({tag, "_awaddr"}, m_axi_awaddr, 32'h0);
    chk({tag, "_araddr"}, m_axi_araddr, 32'h0);
    chk({tag, "_wdata"}, m_axi_wdata, 32'h0);
    chk({tag, "_wstrb_rdata"}, 32'(m_axi_wstrb) | rsp_rdata, 32'h0);
  endtask

  task automatic drive_req(input logic we, input logic [31:0] a, input logic [1:0] s,
                           input logic u, input logic [31:0] wd);
    int n;
    @(negedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = a; req_size = s; req_unsigned = u; req_wdata = wd;
    #1;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); #2; n++; end
    if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'h1);
    @(negedge clk); #1;
    req_valid = 1'b0;
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] a, input logic [1:0] s,
                       input logic u, input logic [31:0] wd);
    logic got;
    drive_req(we, a, s, u, wd);
    lat = 0; aw_first = 0; aw_last = 0; w_last = 0; saw_ar = 0; got = 0;
    for (int cyc = 1; cyc <= 100 && !got; cyc++) begin
      if (m_axi_awvalid) begin
        if (aw_first == 0) aw_first = cyc;
        aw_last = cyc; c_awaddr = m_axi_awaddr;
      end
      if (m_axi_wvalid) begin w_last = cyc; c_wdata = m_axi_wdata; c_wstrb = m_axi_wstrb; end
      if (m_axi_arvalid) saw_ar = 1;
      if (rsp_valid) begin lat = cyc; c_rdata = rsp_rdata; c_err = rsp_err; got = 1; end
      else begin @(negedge clk); #2; end
    end
    if (!got) chk("rsp_timeout", 32'(got), 32'h1);
  endtask

  initial begin
    logic seen;
    int n;
    repeat (3) @(negedge clk);
    #2 check_reset_vals("reset");
    @(negedge clk); #1 rst = 1'b0;

    // word store, zero-wait slave
    issue(1'b1, 32'h0000_0104, 2'd2, 1'b0, 32'hDEAD_BEEF);
    chk("wstore_awaddr", c_awaddr, 32'h104);
    chk("wstore_wstrb", 32'(c_wstrb), 32'hF);
    chk("wstore_wdata", c_wdata, 32'hDEAD_BEEF);
    chk("wstore_aw_cycle", 32'(aw_first), 32'd1);
    chk("wstore_w_cycle", 32'(w_last), 32'd1);
    chk("wstore_latency", 32'(lat), 32'd3);
    chk("wstore_err", 32'(c_err), 32'd0);

    issue(1'b1, 32'h0000_0003, 2'd0, 1'b0, 32'h0000_005A);
    chk("bstore_wdata", c_wdata, 32'h5A5A_5A5A);
    chk("bstore_wstrb", 32'(c_wstrb), 32'h8);

    issue(1'b1, 32'h0000_0002, 2'd1, 1'b0, 32'h0000_1234);
    chk("hstore_wstrb", 32'(c_wstrb), 32'hC);
    chk("hstore_wdata", c_wdata, 32'h1234_1234);

    nxt_rdata = 32'h0000_8000;
    issue(1'b0, 32'h0000_0001, 2'd0, 1'b0, 32'h0);
    chk("bload_signed", c_rdata, 32'hFFFF_FF80);
    chk("bload_latency", 32'(lat), 32'd3);
    issue(1'b0, 32'h0000_0001, 2'd0, 1'b1, 32'h0);
    chk("bload_unsigned", c_rdata, 32'h0000_0080);

    issue(1'b0, 32'h0000_0002, 2'd2, 1'b0, 32'h0);
    chk("misalign_no_ar", 32'(saw_ar), 32'd0);
    chk("misalign_latency", 32'(lat), 32'd1);
    chk("misalign_err", 32'(c_err), 32'd1);
    chk("misalign_rdata", c_rdata, 32'h0);

    // AW accepted at once, W late, slave error
    w_dly = 3; nxt_bresp = 2'b10;
    issue(1'b1, 32'h0000_0010, 2'd2, 1'b0, 32'h0BAD_F00D);
    chk("split_aw_last", 32'(aw_last), 32'd1);
    chk("split_w_last", 32'(w_last), 32'd4);
    chk("split_latency", 32'(lat), 32'd6);
    chk("split_err", 32'(c_err), 32'd1);
    w_dly = 0; nxt_bresp = 2'b00;

    // reset while waiting for read data
    r_dly = 1000;
    drive_req(1'b0, 32'h0000_0020, 2'd2, 1'b0, 32'h0);
    n = 0;
    while (!m_axi_rready && n < 20) begin @(negedge clk); #2; n++; end
    chk("abort_in_rresp", 32'(m_axi_rready), 32'd1);
    @(negedge clk); #1 rst = 1'b1;
    #1 check_reset_vals("midreset");
    @(negedge clk); #1 rst = 1'b0;
    r_dly = 0;
    seen = 0;
    repeat (5) begin @(negedge clk); #2; if (rsp_valid) seen = 1; end
    chk("abort_no_rsp", 32'(seen), 32'd0);
    nxt_rdata = 32'h1122_3344;
    issue(1'b0, 32'h0000_0040, 2'd2, 1'b0, 32'h0);
    chk("post_reset_rdata", c_rdata, 32'h1122_3344);
    chk("post_reset_latency", 32'(lat), 32'd3);

    // randomized traffic, checked cycle by cycle by the compare process
    n = n_rsp;
    rnd_mode = 1'b1;
    repeat (4000) begin
      @(negedge clk); #1;
      aw_rnd = 1'($urandom); w_rnd = 1'($urandom); ar_rnd = 1'($urandom);
      req_valid = 1'($urandom); req_we = 1'($urandom);
      req_addr = $urandom % 256;
      req_size = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
      req_unsigned = 1'($urandom); req_wdata = $urandom;
    end
    @(negedge clk); #1 req_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("random_progress", 32'(n_rsp - n > 200), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
